// File: rtl/clint_types_pkg.sv
// Shared register map, handshake state type and byte-lane helper for the
// core-local timer/software interrupt block.
package clint_types_pkg;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } clint_state_t;

  // Lanes with their enable set take the new byte, the rest keep the old one.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res_v;
    res_v = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res_v[8*i +: 8] = new_v[8*i +: 8];
      else       res_v[8*i +: 8] = old_v[8*i +: 8];
    end
    return res_v;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides the core clock into mtime ticks; clear restarts the division so a
// software write to mtime gets a full PRESCALE period before the next tick.
module clint_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  output logic tick
);

  logic [15:0] count_r;
  logic [15:0] count_nxt_s;

  assign tick = (count_r == 16'(PRESCALE - 1));

  // Next count: restart on clear or on wrap, otherwise advance.
  always_comb begin
    count_nxt_s = count_r;
    if (clear)     count_nxt_s = 16'h0000;
    else if (tick) count_nxt_s = 16'h0000;
    else           count_nxt_s = count_r + 16'h0001;
  end

  // Division counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_r <= 16'h0000;
    else       count_r <= count_nxt_s;
  end

endmodule

// File: rtl/prv_clint_timer.sv
// Core-local interruptor: free-running mtime, mtimecmp and msip behind a
// one-wait-cycle request/busy bus, driving timer_int and soft_int.
module prv_clint_timer
  import clint_types_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
  parameter int          PRESCALE  = 1,
  parameter int          ADDR_W    = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        timer_int,
  output logic        soft_int,
  output logic [63:0] mtime_o
);

  clint_state_t      state_r, state_nxt_s;
  logic              req_wr_r, req_in_win_r;
  logic [ADDR_W-1:0] req_off_r;
  logic [31:0]       req_wdata_r;
  logic [3:0]        req_be_r;

  logic [63:0] mtime_r, mtime_nxt_s;
  logic [63:0] mtimecmp_r, mtimecmp_nxt_s;
  logic        msip_r, msip_nxt_s;
  logic [31:0] rdata_r, rd_val_s;
  logic        busy_r, timer_int_r;

  logic [31:0]       off_full_s;
  logic [ADDR_W-1:0] off_s;
  logic              in_win_s, capture_s, commit_s, tick_s, clear_s;
  logic              wr_msip_s, wr_cmp_lo_s, wr_cmp_hi_s, wr_mt_lo_s, wr_mt_hi_s;

  assign off_full_s = addr - BASE_ADDR;
  assign off_s      = off_full_s[ADDR_W-1:0];
  assign in_win_s   = (off_full_s[31:ADDR_W] == {(32-ADDR_W){1'b0}});
  assign capture_s  = (state_r == IDLE) && (ren || wen);
  // A write lands on the RESP->IDLE edge, so a reset during RESP drops it.
  assign commit_s   = (state_r == RESP) && req_wr_r && req_in_win_r;

  assign wr_msip_s   = commit_s && (req_off_r == ADDR_W'(MSIP_OFF));
  assign wr_cmp_lo_s = commit_s && (req_off_r == ADDR_W'(MTIMECMP_LO_OFF));
  assign wr_cmp_hi_s = commit_s && (req_off_r == ADDR_W'(MTIMECMP_HI_OFF));
  assign wr_mt_lo_s  = commit_s && (req_off_r == ADDR_W'(MTIME_LO_OFF));
  assign wr_mt_hi_s  = commit_s && (req_off_r == ADDR_W'(MTIME_HI_OFF));
  assign clear_s     = wr_mt_lo_s || wr_mt_hi_s;

  clint_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .CLK   (CLK),
    .nRST  (nRST),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // Handshake next state: one response cycle per accepted request.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (ren || wen) state_nxt_s = RESP;
        else            state_nxt_s = IDLE;
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Register read mux over the live register values.
  always_comb begin
    rd_val_s = 32'h0000_0000;
    if (in_win_s) begin
      case (off_s)
        ADDR_W'(MSIP_OFF):        rd_val_s = {31'h0000_0000, msip_r};
        ADDR_W'(MTIMECMP_LO_OFF): rd_val_s = mtimecmp_r[31:0];
        ADDR_W'(MTIMECMP_HI_OFF): rd_val_s = mtimecmp_r[63:32];
        ADDR_W'(MTIME_LO_OFF):    rd_val_s = mtime_r[31:0];
        ADDR_W'(MTIME_HI_OFF):    rd_val_s = mtime_r[63:32];
        default:                  rd_val_s = 32'h0000_0000;
      endcase
    end else begin
      rd_val_s = 32'h0000_0000;
    end
  end

  // Register next values; a bus write to mtime overrides the tick with no carry.
  always_comb begin
    mtime_nxt_s    = mtime_r;
    mtimecmp_nxt_s = mtimecmp_r;
    msip_nxt_s     = msip_r;
    if (wr_mt_lo_s)
      mtime_nxt_s = {mtime_r[63:32], merge_lanes(mtime_r[31:0], req_wdata_r, req_be_r)};
    else if (wr_mt_hi_s)
      mtime_nxt_s = {merge_lanes(mtime_r[63:32], req_wdata_r, req_be_r), mtime_r[31:0]};
    else if (tick_s)
      mtime_nxt_s = mtime_r + 64'd1;
    else
      mtime_nxt_s = mtime_r;
    if (wr_cmp_lo_s)
      mtimecmp_nxt_s = {mtimecmp_r[63:32], merge_lanes(mtimecmp_r[31:0], req_wdata_r, req_be_r)};
    else if (wr_cmp_hi_s)
      mtimecmp_nxt_s = {merge_lanes(mtimecmp_r[63:32], req_wdata_r, req_be_r), mtimecmp_r[31:0]};
    else
      mtimecmp_nxt_s = mtimecmp_r;
    if (wr_msip_s && req_be_r[0]) msip_nxt_s = req_wdata_r[0];
    else                          msip_nxt_s = msip_r;
  end

  // Handshake state and captured request.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r      <= IDLE;
      req_wr_r     <= 1'b0;
      req_in_win_r <= 1'b0;
      req_off_r    <= {ADDR_W{1'b0}};
      req_wdata_r  <= 32'h0000_0000;
      req_be_r     <= 4'h0;
    end else begin
      state_r <= state_nxt_s;
      if (capture_s) begin
        req_wr_r     <= wen;
        req_in_win_r <= in_win_s;
        req_off_r    <= off_s;
        req_wdata_r  <= wdata;
        req_be_r     <= byte_en;
      end
    end
  end

  // Timer registers and registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mtime_r     <= 64'd0;
      mtimecmp_r  <= MTIMECMP_RESET;
      msip_r      <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      busy_r      <= 1'b1;
      timer_int_r <= 1'b0;
    end else begin
      mtime_r     <= mtime_nxt_s;
      mtimecmp_r  <= mtimecmp_nxt_s;
      msip_r      <= msip_nxt_s;
      rdata_r     <= (capture_s && ren && !wen) ? rd_val_s : 32'h0000_0000;
      busy_r      <= (state_nxt_s == IDLE);
      timer_int_r <= (mtime_nxt_s >= mtimecmp_nxt_s);
    end
  end

  assign rdata     = rdata_r;
  assign busy      = busy_r;
  assign timer_int = timer_int_r;
  assign soft_int  = msip_r;
  assign mtime_o   = mtime_r;

endmodule

// File: tb/tb_prv_clint_timer.sv
// Directed and randomized bench for prv_clint_timer against an arithmetic
// model of mtime/mtimecmp/msip, with a second PRESCALE=4 instance.
module tb_prv_clint_timer;

  localparam bit [31:0] BASE   = 32'hF000_0000;
  localparam bit [15:0] O_MSIP = 16'h0000;
  localparam bit [15:0] O_CLO  = 16'h4000;
  localparam bit [15:0] O_CHI  = 16'h4004;
  localparam bit [15:0] O_TLO  = 16'hBFF8;
  localparam bit [15:0] O_THI  = 16'hBFFC;

  logic        clk, nrst;
  logic        ren, wen, ren4, wen4;
  logic [31:0] addr, wdata;
  logic [3:0]  byte_en;
  logic [31:0] rdata, rdata4;
  logic        busy, busy4, timer_int, timer_int4, soft_int, soft_int4;
  logic [63:0] mtime_o, mtime_o4;

  prv_clint_timer #(.PRESCALE(1)) dut (
    .CLK(clk), .nRST(nrst), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
    .byte_en(byte_en), .rdata(rdata), .busy(busy), .timer_int(timer_int),
    .soft_int(soft_int), .mtime_o(mtime_o)
  );

  prv_clint_timer #(.PRESCALE(4)) dut4 (
    .CLK(clk), .nRST(nrst), .ren(ren4), .wen(wen4), .addr(addr), .wdata(wdata),
    .byte_en(byte_en), .rdata(rdata4), .busy(busy4), .timer_int(timer_int4),
    .soft_int(soft_int4), .mtime_o(mtime_o4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model of the PRESCALE=1 instance: register contents after each edge.
  bit [63:0] m_mtime, m_cmp;
  bit        m_msip;
  bit        pw_valid;
  bit [15:0] pw_off;
  bit [31:0] pw_data;
  bit [3:0]  pw_be;
  // Model of the PRESCALE=4 instance: mtime = base4 + (edges since anchor)/4.
  bit [63:0] base4;
  bit [63:0] k4;
  bit        pw4_valid;
  bit [31:0] pw4_data;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] lanes(bit [31:0] old_v, bit [31:0] new_v, bit [3:0] be);
    bit [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic bit [31:0] model_read(bit [15:0] off);
    case (off)
      O_MSIP:  return {31'd0, m_msip};
      O_CLO:   return m_cmp[31:0];
      O_CHI:   return m_cmp[63:32];
      O_TLO:   return m_mtime[31:0];
      O_THI:   return m_mtime[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit [63:0] m4();
    return base4 + (k4 / 64'd4);
  endfunction

  task automatic model_edge();
    bit [63:0] cur;
    bit        bump;
    bump = 1'b1;
    if (pw_valid) begin
      case (pw_off)
        O_TLO: begin m_mtime[31:0]  = lanes(m_mtime[31:0],  pw_data, pw_be); bump = 1'b0; end
        O_THI: begin m_mtime[63:32] = lanes(m_mtime[63:32], pw_data, pw_be); bump = 1'b0; end
        O_CLO: m_cmp[31:0]  = lanes(m_cmp[31:0],  pw_data, pw_be);
        O_CHI: m_cmp[63:32] = lanes(m_cmp[63:32], pw_data, pw_be);
        O_MSIP: m_msip = pw_be[0] ? pw_data[0] : m_msip;
        default: ;
      endcase
      pw_valid = 1'b0;
    end
    if (bump) m_mtime = m_mtime + 64'd1;
    if (pw4_valid) begin
      cur   = m4();
      base4 = {cur[63:32], pw4_data};
      k4    = 64'd0;
      pw4_valid = 1'b0;
    end else begin
      k4 = k4 + 64'd1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("mtime", mtime_o, m_mtime);
    chk("timer_int", timer_int, m_mtime >= m_cmp);
    chk("soft_int", soft_int, m_msip);
    chk("mtime4", mtime_o4, m4());
  endtask

  task automatic bus(bit do_rd, bit do_wr, bit [15:0] off, bit [31:0] d, bit [3:0] be);
    bit [31:0] exp_rd;
    exp_rd  = (do_rd && !do_wr) ? model_read(off) : 32'd0;
    addr    = BASE + {16'd0, off};
    wdata   = d;
    byte_en = be;
    ren     = do_rd;
    wen     = do_wr;
    chk("busy_idle", busy, 1'b1);
    cyc();
    ren = 1'b0;
    wen = 1'b0;
    chk("busy_resp", busy, 1'b0);
    chk("rdata", rdata, exp_rd);
    if (do_wr) begin
      pw_valid = 1'b1; pw_off = off; pw_data = d; pw_be = be;
    end
    cyc();
    chk("busy_done", busy, 1'b1);
  endtask

  task automatic model_reset();
    m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_msip = 1'b0; pw_valid = 1'b0;
    base4 = 64'd0; k4 = 64'd0; pw4_valid = 1'b0;
  endtask

  initial begin
    bit [15:0] offs [7];
    bit [63:0] w4;
    offs = '{O_MSIP, O_CLO, O_CHI, O_TLO, O_THI, 16'h0008, 16'h4008};
    ren = 1'b0; wen = 1'b0; ren4 = 1'b0; wen4 = 1'b0;
    addr = 32'd0; wdata = 32'd0; byte_en = 4'd0;
    nrst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    chk("rst_mtime", mtime_o, 64'd0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_timer", timer_int, 1'b0);
    chk("rst_soft", soft_int, 1'b0);

    // Free-run, then read the reset value of mtimecmp high.
    repeat (10) cyc();
    chk("mtime_10", mtime_o, 64'd10);
    bus(1'b1, 1'b0, O_CHI, 32'd0, 4'h0);

    // Compare at 40, then move compare far ahead.
    bus(1'b0, 1'b1, O_CHI, 32'd0, 4'hF);
    bus(1'b0, 1'b1, O_CLO, 32'd40, 4'hF);
    for (int i = 0; i < 40 && m_mtime < 64'd45; i++) begin
      cyc();
      if (m_mtime == 64'd39) chk("timer_before_40", timer_int, 1'b0);
      if (m_mtime == 64'd40) chk("timer_at_40", timer_int, 1'b1);
    end
    bus(1'b0, 1'b1, O_CLO, 32'd1000, 4'hF);
    chk("timer_dropped", timer_int, 1'b0);

    // Carry from low to high half.
    bus(1'b0, 1'b1, O_THI, 32'd0, 4'hF);
    bus(1'b0, 1'b1, O_TLO, 32'hFFFF_FFFE, 4'hF);
    repeat (2) cyc();
    chk("carry", mtime_o, 64'h1_0000_0000);

    // msip lane handling.
    bus(1'b0, 1'b1, O_MSIP, 32'd1, 4'b0001);
    chk("msip_set", soft_int, 1'b1);
    bus(1'b0, 1'b1, O_MSIP, 32'd0, 4'b0010);
    chk("msip_lane1", soft_int, 1'b1);
    bus(1'b0, 1'b1, O_MSIP, 32'd0, 4'b0001);
    chk("msip_clr", soft_int, 1'b0);

    // Simultaneous ren/wen acts as write; unmapped offsets.
    bus(1'b1, 1'b1, O_CLO, 32'd2000, 4'b0011);
    bus(1'b0, 1'b1, 16'h0008, 32'hDEAD_BEEF, 4'hF);
    bus(1'b1, 1'b0, 16'h4008, 32'd0, 4'h0);

    // Randomized register traffic.
    for (int n = 0; n < 80; n++) begin
      bit rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (rd || wr)
        bus(rd, wr, offs[$urandom_range(0, 6)], $urandom(), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) cyc();
    end

    // Reset during the response cycle of a write: nothing commits.
    addr = BASE + {16'd0, O_CLO}; wdata = 32'h0000_1234; byte_en = 4'hF; wen = 1'b1;
    cyc();
    wen = 1'b0;
    chk("busy_resp_pre_rst", busy, 1'b0);
    nrst = 1'b0;
    model_reset();
    @(posedge clk);
    #1 nrst = 1'b1;
    chk("rst_mid_busy", busy, 1'b1);
    chk("rst_mid_mtime", mtime_o, 64'd0);
    bus(1'b1, 1'b0, O_CLO, 32'd0, 4'h0);

    // PRESCALE=4: mtime_lo write committing on a tick edge.
    for (int i = 0; i < 8 && (k4 % 64'd4) != 64'd2; i++) cyc();
    addr = BASE + {16'd0, O_TLO}; wdata = 32'h0000_1000; byte_en = 4'hF; wen4 = 1'b1;
    chk("busy4_idle", busy4, 1'b1);
    cyc();
    wen4 = 1'b0;
    chk("busy4_resp", busy4, 1'b0);
    w4 = {m4() >> 32, 32'h0000_1000};
    pw4_valid = 1'b1; pw4_data = 32'h0000_1000;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("hold4", mtime_o4, w4);
    end
    cyc();
    chk("inc4", mtime_o4, w4 + 64'd1);
    chk("busy4_done", busy4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prv_clint_timer.md
Name: prv_clint_timer

Overview:
- Core-local interruptor that produces the machine timer and software interrupt inputs (timer_int, soft_int) consumed by the privilege block.
- Holds a free-running 64-bit mtime counter, a 64-bit mtimecmp compare register and an msip register.
- All three are exposed to the data bus as word-addressed memory-mapped registers with a simple request/busy handshake.

Parameters:
- BASE_ADDR, 32'hF000_0000, byte base address of the register window.
- PRESCALE, 1, core cycles per mtime increment; legal range 1..65535.
- ADDR_W, 16, offset bits decoded within the window.

Ports:
- CLK  input  1  core clock
- nRST  input  1  asynchronous active-low reset
- ren  input  1  bus read request
- wen  input  1  bus write request
- addr  input  32  byte address
- wdata  input  32  write data
- byte_en  input  4  byte lane enables for writes
- rdata  output  32  read data
- busy  output  1  high while a request is not yet complete
- timer_int  output  1  to priv block: mtime >= mtimecmp
- soft_int  output  1  to priv block: msip[0]
- mtime_o  output  64  current mtime, for the time/timeh CSR shadow

Behaviour:
- Reset: one clock (CLK); reset is asynchronous and active-low (nRST).
- Reset values:
  - mtime = 0, prescale counter = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0.
  - rdata = 0, busy = 1 (idle value), timer_int = 0, soft_int = 0.
- Register map (offset = addr - BASE_ADDR):
  - 0x0000 msip: bit0 only, upper bits read 0.
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
  - Unmapped in-window offsets read 0 and ignore writes. Addresses outside the window are not this block's responsibility (decoded upstream).
- Handshake FSM, states IDLE and RESP:
  - IDLE: busy = 1. If ren or wen is sampled, capture the request and go to RESP.
  - RESP: busy = 0 for exactly one cycle. For reads, rdata holds the captured register value. For writes, the register update commits at this edge. Then return to IDLE.
  - Request-to-completion latency is therefore 1 wait cycle.
  - ren and wen both high: treated as a write; rdata = 0.
- Counter:
  - The prescale counter counts 0..PRESCALE-1. mtime increments by 1 on the cycle the counter wraps; PRESCALE = 1 means every cycle.
  - mtime wraps modulo 2^64. The low half carries into the high half within the same cycle.
- Write precedence:
  - A bus write to either mtime half in the same cycle as a tick wins. The written half takes wdata (byte-masked); the other half keeps its pre-tick value, with no carry. The prescale counter resets to 0.
- Byte enables apply per lane to all writable registers. msip uses lane 0 bit0 only.
- Outputs:
  - timer_int is registered: the unsigned 64-bit compare of the next-state mtime against the next-state mtimecmp.
  - It asserts in the same cycle mtime first equals mtimecmp. It drops the cycle after a write makes mtimecmp > mtime.
  - soft_int = msip[0] (register output).
- Reset mid-transaction aborts the request: FSM returns to IDLE and no partial write commits.

Decomposition:
- Add a clint_types_pkg with:
  - the offset constants MSIP_OFF, MTIMECMP_LO_OFF, MTIMECMP_HI_OFF, MTIME_LO_OFF, MTIME_HI_OFF;
  - a clint_state_t enum {IDLE, RESP};
  - MTIMECMP_RESET.
- One sub-module, clint_prescaler: the tick generator, taking a clear input and producing a tick output.

Test Plan:
- Reset, PRESCALE = 1, no bus activity for 10 cycles -> mtime_o = 10, timer_int = 0, soft_int = 0, read of 0x4004 returns 32'hFFFF_FFFF.
- Write mtimecmp_hi = 0, then mtimecmp_lo = 40 -> timer_int rises in the exact cycle mtime_o = 40. Then write mtimecmp_lo = 1000 -> timer_int drops one cycle after the write completes.
- Write mtime_lo = 32'hFFFF_FFFE, mtime_hi = 0 -> two ticks later mtime_o = 64'h1_0000_0000, proving the carry.
- Write msip with byte_en = 4'b0001, wdata = 1 -> soft_int = 1. Same write with byte_en = 4'b0010 -> no change. Write 0 -> soft_int = 0.
- PRESCALE = 4, write mtime_lo coinciding with a tick -> mtime_o holds the written value for the next 4 cycles before incrementing.
- Read any register -> busy = 1 for 1 cycle, then busy = 0 with correct rdata. Assert nRST during the RESP of a write -> the register is unchanged after reset release.
